// File: rtl/uart_bus_responder_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, CON bit
// positions and the serial FSM state encoding (UART_PARITY_EN adds parity).
package uart_bus_responder_pkg;

    localparam logic [31:0] TXD_OFS = 32'h0;
    localparam logic [31:0] RXD_OFS = 32'h4;
    localparam logic [31:0] CON_OFS = 32'h8;

    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_VALID = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_OVR_ERR  = 5;
    localparam int CON_FRM_ERR  = 6;
    localparam int CON_PAR_ERR  = 7;

    // One encoding serves both serial FSMs; PARITY is only reachable with UART_PARITY_EN.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_bus_responder_rx.sv
// Serial receiver: 2-flop synchronizer, mid-bit sampling RX FSM, emits a byte
// with one-cycle valid/frm_err/par_err pulses. Parity bit handled when UART_PARITY_EN.
module uart_rx_deserializer
    import uart_bus_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  data,
    output logic        valid,
    output logic        frm_err,
    output logic        par_err,
    output uart_state_e state
);

    localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta, rx_sync, rx_prev;
    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
`ifdef UART_PARITY_EN
    logic          par_bad_q, par_bad_d;
`endif

    // Synchronizer flops reset to the idle-high line level so reset itself is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
`ifdef UART_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
`ifdef UART_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        valid     = 1'b0;
        frm_err   = 1'b0;
        par_err   = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_prev && !rx_sync) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_sync != even_parity(shift_q));
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    frm_err = !rx_sync;
`ifdef UART_PARITY_EN
                    par_err = par_bad_q;
                    valid   = rx_sync && !par_bad_q;
`else
                    valid   = rx_sync;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data  = shift_q;
    assign state = state_q;

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART responder: TXD/RXD/CON registers, TX serializer and IRQ.
// Define UART_PARITY_EN for 8E1 frames with CON[7] parity error reporting.
module uart_bus_responder
    import uart_bus_responder_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    // Bus handshake: rd/wr are single-cycle strobes with no ready; every access
    // completes in the cycle it is presented and rdata is valid in that same cycle.
    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign sel_txd = (addr == BASE_ADDR + TXD_OFS);
    assign sel_rxd = (addr == BASE_ADDR + RXD_OFS);
    assign sel_con = (addr == BASE_ADDR + CON_OFS);
    assign wr_txd  = wr & sel_txd;
    assign wr_con  = wr & sel_con;
    assign rd_rxd  = rd & sel_rxd;
    assign rd_con  = rd & sel_con;

    logic [7:0] txd_q, rx_data_q;
    logic       tx_ie_q, rx_ie_q, tx_done_q, rx_valid_q, tx_busy_q;
    logic       ovr_q, frm_q, par_q, irq_q;

    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic          tx_q, tx_d, tx_frame_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q + CW'(1);
        tx_bit_d      = tx_bit_q;
        tx_frame_done = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (tx_busy_q) tx_state_d = ST_START;
            end
            ST_START: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = ST_PARITY;
`else
                        tx_state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tx_cnt_q == LAST) begin
                    tx_state_d    = ST_IDLE;
                    tx_frame_done = 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        // The line level is decoded from the next state and registered, so tx never glitches.
        case (tx_state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = txd_q[tx_bit_d];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = even_parity(txd_q);
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    logic [7:0]  rx_byte;
    logic        rx_byte_valid, rx_frm, rx_par;
    uart_state_e rx_state;

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .data   (rx_byte),
        .valid  (rx_byte_valid),
        .frm_err(rx_frm),
        .par_err(rx_par),
        .state  (rx_state)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txd_q     <= '0;
            tx_busy_q <= 1'b0;
            tx_ie_q   <= 1'b0;
            rx_ie_q   <= 1'b0;
            rx_data_q <= '0;
        end else begin
            if (wr_txd && !tx_busy_q) begin
                txd_q     <= wdata[7:0];
                tx_busy_q <= 1'b1;
            end else if (tx_frame_done) begin
                tx_busy_q <= 1'b0;
            end
            if (wr_con) {rx_ie_q, tx_ie_q} <= wdata[1:0];
            if (rx_byte_valid) rx_data_q <= rx_byte;
        end
    end

    // Sticky status: a set in the same cycle as its clearing read wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            par_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (tx_frame_done)                            tx_done_q  <= 1'b1;
            else if (rd_con)                              tx_done_q  <= 1'b0;
            if (rx_byte_valid)                            rx_valid_q <= 1'b1;
            else if (rd_rxd)                              rx_valid_q <= 1'b0;
            if (rx_byte_valid && rx_valid_q && !rd_rxd)   ovr_q      <= 1'b1;
            else if (rd_con)                              ovr_q      <= 1'b0;
            if (rx_frm)                                   frm_q      <= 1'b1;
            else if (rd_con)                              frm_q      <= 1'b0;
            if (rx_par)                                   par_q      <= 1'b1;
            else if (rd_con)                              par_q      <= 1'b0;
            irq_q <= (tx_done_q & tx_ie_q) | (rx_valid_q & rx_ie_q);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd) begin
                rdata = {24'h0, txd_q};
            end else if (sel_rxd) begin
                rdata = {24'h0, rx_data_q};
            end else if (sel_con) begin
                rdata[CON_TX_IE]    = tx_ie_q;
                rdata[CON_RX_IE]    = rx_ie_q;
                rdata[CON_TX_DONE]  = tx_done_q;
                rdata[CON_RX_VALID] = rx_valid_q;
                rdata[CON_TX_BUSY]  = tx_busy_q;
                rdata[CON_OVR_ERR]  = ovr_q;
                rdata[CON_FRM_ERR]  = frm_q;
                rdata[CON_PAR_ERR]  = par_q;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], rx_state};

    assign tx  = tx_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder (default 8N1 build, CLKS_PER_BIT=16)
// with expected-value queues for the serial TX bits and received RX bytes.
module tb_uart_bus_responder;

    localparam int          CPB         = 16;
    localparam logic [31:0] A_TXD       = 32'h4000_0018;
    localparam logic [31:0] A_RXD       = 32'h4000_001C;
    localparam logic [31:0] A_CON       = 32'h4000_0020;
    // Negedge index inside an RX frame where the stop bit is sampled:
    // mid stop bit plus the synchronizer and edge-detect latency.
    localparam int          STOP_SAMPLE = 9 * CPB + CPB / 2 + 2;

    logic        clk = 1'b0;
    logic        reset, rd, wr, rx, tx, irq;
    logic [31:0] addr, wdata, rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] tx_exp_q[$];
    logic [31:0] rx_exp_q[$];
    logic        exp_ovr = 1'b0;
    logic [31:0] exp_val;

    always #5 clk = ~clk;

    uart_bus_responder #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (A_TXD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rd   (rd),
        .wr   (wr),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .rx   (rx),
        .tx   (tx),
        .irq  (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) begin
            @(negedge clk);
            rd = 1'b0;
            wr = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] a);
        addr = a;
        rd   = 1'b1;
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_exp_q.push_back(32'h0);
        for (int i = 0; i < 8; i++) tx_exp_q.push_back({31'h0, b[i]});
        tx_exp_q.push_back(32'h1);
    endtask

    // A landing byte overwrites an unread one and flags overrun.
    task automatic rx_land(input logic [7:0] b);
        if (rx_exp_q.size() > 0) begin
            void'(rx_exp_q.pop_back());
            exp_ovr = 1'b1;
        end
        rx_exp_q.push_back({24'h0, b});
    endtask

    task automatic read_rxd(input string tag);
        do_read(A_RXD);
        exp_val = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 32'hFFFF_FFFF;
        check(tag, rdata, exp_val);
    endtask

    task automatic check_tx_frame(input int inject_at, input logic [7:0] inject_val);
        int waited;
        waited = 0;
        while (tx !== 1'b0 && waited < 64) begin
            wait_neg(1);
            waited++;
        end
        check("tx_start_seen", {31'h0, tx}, 32'h0);
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k % CPB == CPB / 2) begin
                exp_val = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 32'hFFFF_FFFF;
                check("tx_bit", {31'h0, tx}, exp_val);
            end
            if (k == CPB / 2) begin
                do_read(A_CON);
                check("con_busy", {31'h0, rdata[4]}, 32'h1);
            end
            if (k == inject_at) do_write(A_TXD, {24'h0, inject_val});
            wait_neg(1);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int rd_at);
        int bi;
        for (int c = 0; c < 10 * CPB; c++) begin
            bi = c / CPB;
            if (bi == 0)      rx = 1'b0;
            else if (bi == 9) rx = stop;
            else              rx = b[bi-1];
            if (c == rd_at) read_rxd("rxd_at_stop_sample");
            wait_neg(1);
        end
        if (stop) rx_land(b);
        rx = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        rx    = 1'b1;
        wait_neg(3);
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b1;
        wait_neg(2);
        do_read(A_CON); check("reset_con", rdata, 32'h0); wait_neg(1);
        do_read(A_TXD); check("reset_txd", rdata, 32'h0); wait_neg(1);
        do_read(A_RXD); check("reset_rxd", rdata, 32'h0); wait_neg(1);

        // Reset in the middle of a transmitted frame.
        do_write(A_TXD, 32'hA5);
        wait_neg(40);
        reset = 1'b0;
        #1;
        check("midreset_tx", {31'h0, tx}, 32'h1);
        check("midreset_irq", {31'h0, irq}, 32'h0);
        wait_neg(3);
        reset = 1'b1;
        wait_neg(1);
        do_read(A_CON); check("midreset_con", rdata, 32'h0); wait_neg(1);
        check("midreset_tx_idle", {31'h0, tx}, 32'h1);

        // TX frame with completion interrupt.
        do_write(A_CON, 32'h1); wait_neg(1);
        do_write(A_TXD, 32'hA5); push_tx(8'hA5); wait_neg(1);
        check_tx_frame(-1, 8'h00);
        check("tx_irq_before", {31'h0, irq}, 32'h0);
        wait_neg(1);
        check("tx_irq_after", {31'h0, irq}, 32'h1);
        do_read(A_CON); check("tx_con_done", rdata, 32'h5); wait_neg(1);
        do_read(A_CON); check("tx_con_cleared", rdata, 32'h1); wait_neg(1);

        // A write while busy is dropped.
        do_write(A_TXD, 32'h3C); push_tx(8'h3C); wait_neg(1);
        check_tx_frame(CPB + 2, 8'hFF);
        do_read(A_TXD); check("busy_txd", rdata, 32'h3C); wait_neg(1);
        do_read(A_CON); check("busy_con", rdata, 32'h5); wait_neg(1);
        wait_neg(20);
        check("busy_no_resend", {31'h0, tx}, 32'h1);

        // RX with interrupt, then overrun.
        do_write(A_CON, 32'h2); wait_neg(1);
        send_rx(8'h5A, 1'b1, -1);
        check("rx_irq_rise", {31'h0, irq}, 32'h1);
        read_rxd("rxd_5a");
        wait_neg(2);
        check("rx_irq_fall", {31'h0, irq}, 32'h0);
        send_rx(8'h11, 1'b1, -1);
        send_rx(8'h22, 1'b1, -1);
        read_rxd("rxd_overrun"); wait_neg(1);
        do_read(A_CON); check("con_overrun", rdata, 32'h2 | (exp_ovr ? 32'h20 : 32'h0));
        exp_ovr = 1'b0;
        wait_neg(1);
        do_read(A_CON); check("con_ovr_cleared", rdata, 32'h2); wait_neg(1);

        // False start glitch, then a framing error.
        rx = 1'b0; wait_neg(4); rx = 1'b1;
        wait_neg(3 * CPB);
        do_read(A_CON); check("glitch_con", rdata, 32'h2); wait_neg(1);
        check("glitch_irq", {31'h0, irq}, 32'h0);
        send_rx(8'hC3, 1'b0, -1);
        wait_neg(2);
        do_read(A_CON); check("frm_con", rdata, 32'h42); wait_neg(1);

        // RXD read in the same cycle a new byte lands.
        send_rx(8'h66, 1'b1, -1);
        send_rx(8'h77, 1'b1, STOP_SAMPLE);
        do_read(A_CON);
        check("simul_con", rdata, 32'h2 | (rx_exp_q.size() > 0 ? 32'h8 : 32'h0) | (exp_ovr ? 32'h20 : 32'h0));
        wait_neg(1);
        read_rxd("rxd_77"); wait_neg(1);

        check("tx_queue_drained", tx_exp_q.size(), 32'h0);
        check("rx_queue_drained", rx_exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
- Memory-mapped UART peripheral: the responder side of the CPU's load/store data bus (rd/wr/addr/wdata/rdata).
- Serializes CPU-written bytes onto the serial line (8N1) and deserializes incoming serial bytes for the CPU to read.
- Raises an interrupt request on TX completion and RX data.
- Sits beside data memory in the MEM stage; the CPU muxes rdata in when addr[31:28] == 4'h4.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud).
- BASE_ADDR, 32'h4000_0018, address of the TXD register; RXD = BASE+4, CON = BASE+8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rd  in  1  bus read strobe, one cycle per access.
- wr  in  1  bus write strobe, one cycle per access.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr/rd.
- rx  in  1  serial input, asynchronous, idle high.
- tx  out  1  serial output, idle high.
- irq  out  1  interrupt request, registered.

Behaviour:
- Reset (reset=0, async): tx=1, irq=0, all registers 0, both FSMs in IDLE. A reset mid-frame aborts the frame; tx returns to 1 immediately.
- Address decode: full 32-bit compare, word aligned. Unmapped address or rd=0 gives rdata=0. Writes to RXD/unmapped addresses are ignored.
- TXD read: returns {24'h0, last written byte}.
- TXD write:
  - If tx_busy=0: latch wdata[7:0], set tx_busy, start a frame on the next cycle.
  - If tx_busy=1: the write is dropped; the TXD register is unchanged.
- TX FSM:
  - IDLE -> START (1 bit time, tx=0) -> DATA (8 bits, LSB first) -> STOP (1 bit time, tx=1) -> IDLE.
  - Each bit time is exactly CLKS_PER_BIT cycles.
  - On leaving STOP: clear tx_busy, set tx_done.
  - Frame length is 10*CLKS_PER_BIT cycles.
- RX path:
  - 2-flop synchronizer on rx.
  - In IDLE, a synchronized falling edge moves to START.
  - START: at CLKS_PER_BIT/2, re-sample. If high, it was a false start: go back to IDLE.
  - DATA: sample at mid-bit every CLKS_PER_BIT, 8 bits LSB first.
  - STOP: sample at mid-bit. If 1, load rx_data and set rx_valid. If 0, it is a framing error: set frm_err, discard the byte.
  - Returns to IDLE right after the stop sample, so back-to-back frames are accepted.
- Overrun: a new byte arriving while rx_valid=1 overwrites rx_data and sets ovr_err.
- RXD read: returns {24'h0, rx_data} and clears rx_valid in the same cycle. If a new byte lands in that same cycle, the new byte wins: rx_valid stays 1 and ovr_err is not set.
- CON register bit map:
  - [0] tx_ie (RW)
  - [1] rx_ie (RW)
  - [2] tx_done (RO, cleared on CON read)
  - [3] rx_valid (RO)
  - [4] tx_busy (RO)
  - [5] ovr_err (RO, cleared on CON read)
  - [6] frm_err (RO, cleared on CON read)
  - [31:7] read 0
- CON write: updates only bits [1:0].
- Simultaneous set and clear on a sticky bit: set wins.
- irq: registered each cycle as (tx_done & tx_ie) | (rx_valid & rx_ie). One cycle of latency from the status change.

Optional Feature:
- UART_PARITY_EN defined:
  - Frames are 8E1; an even parity bit sits between DATA and STOP (PARITY state in both FSMs).
  - TX frame length is 11*CLKS_PER_BIT.
  - An RX parity mismatch sets CON[7] par_err (cleared on CON read) and the byte is discarded.
- UART_PARITY_EN undefined: 8N1 only, no PARITY states, CON[7] reads 0.

Decomposition:
- Shared package holds:
  - register offsets (TXD=0, RXD=4, CON=8);
  - CON bit-index constants;
  - TX/RX state encodings (IDLE, START, DATA, PARITY, STOP).
- One sub-module: uart_rx_deserializer. It contains the synchronizer, RX FSM, bit counter and baud counter, and outputs a byte plus valid/frm_err/par_err pulses.
- TX logic and bus decode stay in the top.

Test Plan (CLKS_PER_BIT=16 in the bench):
- Reset mid-transmit: write TXD=8'hA5, pull reset low at cycle 40 -> tx=1, irq=0, CON reads 0 immediately after release.
- TX: write CON=3'b001, then TXD=8'hA5 -> tx waveform 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. CON[4]=1 during the frame. irq=1 one cycle after stop ends. CON read returns 32'h5, and the next CON read returns 32'h1.
- Busy drop: write TXD=8'h3C, then TXD=8'hFF at cycle 20 -> the serial frame carries 8'h3C; a TXD read returns 32'h3C.
- RX + overrun: CON=3'b010; drive byte 8'h5A on rx -> irq rises, RXD read = 32'h5A, irq falls. Drive 8'h11 then 8'h22 with no read in between -> RXD=32'h22, CON[5]=1.
- Framing/false start: a 4-cycle low glitch on rx gives no rx_valid. A frame with stop=0 gives CON[6]=1 and CON[3]=0.
- Simultaneous: the RXD read cycle coincides with the stop sample of a new byte 8'h77 -> CON[3]=1, ovr_err=0, the next RXD read = 32'h77.
